// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU memory port (master) and dmem_responder (slave).
// Request channel: valid/ready with store data and byte strobes.
// Response channel: valid/ready with load data and an error flag.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding memory responder with programmable latency
// and a word-organised RAM built from four byte-lane arrays.
// Optional feature macro: DMEM_RESP_ALIGN_CHK_EN -- when defined, a request whose
// byte address is not word aligned faults (rsp_err=1, no store, rdata=0).
// When undefined, address bits [1:0] are ignored.
module dmem_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;

    // Request captured at the accept edge
    logic                wr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic                err_q;

    logic                rsp_err_q;
    logic [31:0]         rdata_w;

    // Live-request decode
    logic [31:0]         offset_w;
    logic                below_w;
    logic                beyond_w;
    logic                misalign_w;
    logic                req_err_w;
    logic [ADDR_W-1:0]   req_idx_w;
    logic                accept_w;

    // Fields used at the access point: live inputs when the access happens on
    // the accept edge itself (WAIT_CYCLES==0), captured copy otherwise.
    logic                cur_wr;
    logic [ADDR_W-1:0]   cur_idx;
    logic [31:0]         cur_wdata;
    logic [3:0]          cur_wstrb;
    logic                cur_err;
    logic                access_en;

    assign offset_w  = bus.req_addr - BASE_ADDR;
    assign below_w   = (bus.req_addr < BASE_ADDR);
    assign beyond_w  = ((offset_w >> (ADDR_W + 2)) != 32'd0);
    assign req_idx_w = offset_w[ADDR_W+1:2];

`ifdef DMEM_RESP_ALIGN_CHK_EN
    assign misalign_w = (bus.req_addr[1:0] != 2'b00);
`else
    assign misalign_w = 1'b0;
`endif

    assign req_err_w = below_w | beyond_w | misalign_w;

    assign bus.req_ready = (state_q == S_IDLE) && !rst_i;
    assign accept_w      = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rdata_w;
    assign busy_o        = (state_q != S_IDLE);

    assign cur_wr    = (state_q == S_IDLE) ? bus.req_wr    : wr_q;
    assign cur_idx   = (state_q == S_IDLE) ? req_idx_w     : idx_q;
    assign cur_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;
    assign cur_wstrb = (state_q == S_IDLE) ? bus.req_wstrb : wstrb_q;
    assign cur_err   = (state_q == S_IDLE) ? req_err_w     : err_q;

    // The array is touched exactly once per transaction, on the edge entering RESP.
    assign access_en = (state_d == S_RESP) && (state_q != S_RESP) && !rst_i;

    // State and latency counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> WAIT/RESP on accept, WAIT counts down, RESP waits for rsp_ready
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_w) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 8'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Capture request fields at the accept edge so later req_* changes are ignored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            err_q   <= 1'b0;
        end else if (accept_w) begin
            wr_q    <= bus.req_wr;
            idx_q   <= req_idx_w;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
            err_q   <= req_err_w;
        end
    end

    // Registered error flag, loaded at the access point and held through RESP
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_err_q <= 1'b0;
        end else if (access_en) begin
            rsp_err_q <= cur_err;
        end
    end

    // One byte-wide RAM per lane; store strobes map directly onto lane write enables
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:(1<<ADDR_W)-1];
            logic [7:0] lane_rd_q;

            // Lane write: only successful stores with this lane's strobe set
            always_ff @(posedge clk_i) begin
                if (access_en && cur_wr && !cur_err && cur_wstrb[gi]) begin
                    lane_mem[cur_idx] <= cur_wdata[gi*8 +: 8];
                end
            end

            // Lane read register: load data, forced to zero for stores and faults
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    lane_rd_q <= 8'd0;
                end else if (access_en) begin
                    lane_rd_q <= (cur_wr || cur_err) ? 8'd0 : lane_mem[cur_idx];
                end
            end

            assign rdata_w[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (ADDR_W=10, WAIT_CYCLES=2, BASE_ADDR=0).
// Expectations follow DMEM_RESP_ALIGN_CHK_EN when it is defined for the build.
module tb_dmem_responder;

    logic clk;
    logic rst;
    logic busy;
    int   n_cmp;
    int   n_bad;

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_W      (10),
        .WAIT_CYCLES (2),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction. Returns data, error and the negedge count from the
    // accept edge to the first rsp_valid. Holds rsp_ready low for 'hold' cycles.
    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
        int k;
        rdata = 32'hx;
        err   = 1'bx;
        lat   = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            check({tag, "_accept_timeout"}, 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble request fields after accept; the DUT must ignore them
        bus.req_valid = 1'b0;
        bus.req_wr    = ~wr;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h5555_AAAA;
        bus.req_wstrb = 4'hF;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 20);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"},  32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_rdata"},  bus.rsp_rdata, rdata);
            check({tag, "_hold_rdy"},    32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check({tag, "_done_busy"},  32'(busy), 32'd0);
        check({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
        $display("xact %s wr=%0b addr=%h wdata=%h strb=%h -> rdata=%h err=%0b lat=%0d",
                 tag, wr, addr, wdata, strb, rdata, err, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        seen;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'h0;
        bus.rsp_ready = 1'b0;

        // Reset defaults
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Store then load with latency check
        xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        check("st10_lat",   32'(lat), 32'd3);
        check("st10_err",   32'(er),  32'd0);
        check("st10_rdata", rd,       32'd0);
        xact("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("ld10_lat",   32'(lat), 32'd3);
        check("ld10_rdata", rd,       32'hDEADBEEF);
        check("ld10_err",   32'(er),  32'd0);

        // Byte strobes
        xact("st10_strb", 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd, er, lat);
        check("st10_strb_err", 32'(er), 32'd0);
        xact("ld10_strb", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("ld10_strb_rdata", rd, 32'hDE22BE44);

        // Backpressure: five cycles of rsp_ready low in RESP
        xact("ld10_bp", 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        check("ld10_bp_rdata", rd, 32'hDE22BE44);

        // Range boundaries: last valid word and first out-of-range word
        xact("st_last", 1'b1, 32'hFFC, 32'hA5A5_5A5A, 4'hF, 0, rd, er, lat);
        check("st_last_err", 32'(er), 32'd0);
        xact("ld_last", 1'b0, 32'hFFC, 32'h0, 4'h0, 0, rd, er, lat);
        check("ld_last_rdata", rd, 32'hA5A5_5A5A);
        check("ld_last_err",   32'(er), 32'd0);
        xact("ld_oor", 1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, er, lat);
        check("ld_oor_err",   32'(er), 32'd1);
        check("ld_oor_rdata", rd,      32'd0);
        check("ld_oor_lat",   32'(lat), 32'd3);
        xact("st_oor", 1'b1, 32'h1000, 32'h7777_7777, 4'hF, 0, rd, er, lat);
        check("st_oor_err", 32'(er), 32'd1);
        xact("ld0_alias", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
        // Word 0 may hold anything but must not be the suppressed out-of-range store
        check("ld0_alias_not_written", 32'(rd === 32'h7777_7777), 32'd0);

        // Misaligned store to 0x12
        xact("st12", 1'b1, 32'h12, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
        xact("ld10_mis", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
`ifdef DMEM_RESP_ALIGN_CHK_EN
        check("ld10_mis_rdata", rd, 32'hDE22BE44);
`else
        check("ld10_mis_rdata", rd, 32'hCAFEF00D);
`endif
        xact("ld12", 1'b0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat);
`ifdef DMEM_RESP_ALIGN_CHK_EN
        check("ld12_err",   32'(er), 32'd1);
        check("ld12_rdata", rd,      32'd0);
`else
        check("ld12_err",   32'(er), 32'd0);
        check("ld12_rdata", rd,      32'hCAFEF00D);
`endif

        // Zero-strobe store completes with no change
        xact("st20", 1'b1, 32'h20, 32'h12345678, 4'hF, 0, rd, er, lat);
        xact("st20_z", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
        check("st20_z_err", 32'(er), 32'd0);
        xact("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        check("ld20_rdata", rd, 32'h12345678);

        // Reset while in WAIT drops the store
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h0BADF00D;
        bus.req_wstrb = 4'hF;
        check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        check("mid_rst_no_valid", 32'(seen), 32'd0);
        $display("xact mid_rst store 0x20 dropped, rsp_valid_seen=%0b", seen);
        xact("ld20_post", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        check("ld20_post_rdata", rd, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
